// File: rtl/inertial_interface.sv
// -----------------------------------------------------------------------------
// inertial_interface
//
// Producer side of the inertial data path. After power-up it waits
// INIT_CYCLES clocks, then writes four configuration words to the 6-axis IMU
// through the SPI master. After that, every rising edge of the IMU data-ready
// interrupt starts four single-byte reads: pitch-rate low/high and Z-accel
// low/high. The assembled sample is presented with a one-cycle vld pulse.
//
// Optional feature macro: INERTIAL_TIMEOUT_EN
//   When defined, each SPI transaction is bounded to TIMEOUT_CYCLES clocks.
//   On expiry err pulses for one cycle. An expired config transaction restarts
//   the init wait. An expired read transaction returns to IDLE and leaves the
//   outputs untouched. When undefined, the FSM waits for done indefinitely and
//   err is constant 0.
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   INT      in   IMU data-ready interrupt (asynchronous to clk)
//   done     in   SPI transaction complete, one-cycle pulse
//   rd_data  in   SPI read data, valid while done=1 (only [7:0] is used)
//   wrt      out  one-cycle pulse starting an SPI transaction
//   cmd      out  SPI command word, held from wrt until done
//   vld      out  one-cycle pulse marking a new ptch_rt/AZ sample
//   ptch_rt  out  signed pitch rate {high byte, low byte}
//   AZ       out  signed Z acceleration {high byte, low byte}
//   err      out  one-cycle pulse on SPI timeout
// -----------------------------------------------------------------------------
module inertial_interface #(
  parameter int unsigned INIT_CYCLES    = 65536,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               INT,
  input  logic               done,
  input  logic [15:0]        rd_data,
  output logic               wrt,
  output logic [15:0]        cmd,
  output logic               vld,
  output logic signed [15:0] ptch_rt,
  output logic signed [15:0] AZ,
  output logic               err
);

  localparam int INIT_W = $clog2(INIT_CYCLES + 1);

  typedef enum logic [3:0] {
    INIT_WAIT, CFG0, CFG1, CFG2, CFG3, IDLE,
    RD_PL, RD_PH, RD_AL, RD_AH, SAMPLE
  } state_t;

  state_t            state, state_d;
  logic [INIT_W-1:0] init_cnt;
  logic              int_p0, int_p1, int_p2;
  logic              int_rise;
  logic              xfer, accept, expire;
  logic              wrt_d, vld_d, err_d;
  logic [15:0]       cmd_d;
  logic              ld_pl, ld_ph, ld_al, ld_out;
  logic [7:0]        ptch_lo, ptch_hi, az_lo;
  logic [7:0]        unused_rd_hi;

  assign unused_rd_hi = rd_data[15:8];

  // Stage p0..p1: two-flop INT synchronizer; p2: previous level for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      int_p0 <= 1'b0;
      int_p1 <= 1'b0;
      int_p2 <= 1'b0;
    end else begin
      int_p0 <= INT;
      int_p1 <= int_p0;
      int_p2 <= int_p1;
    end
  end

  assign int_rise = int_p1 & ~int_p2;

  // A transaction state whose wrt cycle is over only listens for done;
  // a done coinciding with wrt belongs to nothing we issued.
  assign xfer   = state inside {CFG0, CFG1, CFG2, CFG3, RD_PL, RD_PH, RD_AL, RD_AH};
  assign accept = xfer & ~wrt & done;

`ifdef INERTIAL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // Counts cycles since wrt; value k means k cycles have elapsed.
  always_ff @(posedge clk) begin
    if (rst || wrt_d || accept || !xfer) to_cnt <= '0;
    else                                 to_cnt <= to_cnt + TO_W'(1);
  end

  assign expire = xfer & ~accept & (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign expire         = 1'b0;
`endif

  always_comb begin
    state_d = state;
    wrt_d   = 1'b0;
    cmd_d   = cmd;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    ld_pl   = 1'b0;
    ld_ph   = 1'b0;
    ld_al   = 1'b0;
    ld_out  = 1'b0;
    unique case (state)
      INIT_WAIT: if (init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
        state_d = CFG0; wrt_d = 1'b1; cmd_d = 16'h0D02;
      end
      CFG0: if (accept) begin
        state_d = CFG1; wrt_d = 1'b1; cmd_d = 16'h1053;
      end else if (expire) begin
        state_d = INIT_WAIT; err_d = 1'b1;
      end
      CFG1: if (accept) begin
        state_d = CFG2; wrt_d = 1'b1; cmd_d = 16'h1150;
      end else if (expire) begin
        state_d = INIT_WAIT; err_d = 1'b1;
      end
      CFG2: if (accept) begin
        state_d = CFG3; wrt_d = 1'b1; cmd_d = 16'h1460;
      end else if (expire) begin
        state_d = INIT_WAIT; err_d = 1'b1;
      end
      CFG3: if (accept) begin
        state_d = IDLE;
      end else if (expire) begin
        state_d = INIT_WAIT; err_d = 1'b1;
      end
      IDLE: if (int_rise) begin
        state_d = RD_PL; wrt_d = 1'b1; cmd_d = 16'hA200;
      end
      RD_PL: if (accept) begin
        state_d = RD_PH; wrt_d = 1'b1; cmd_d = 16'hA300; ld_pl = 1'b1;
      end else if (expire) begin
        state_d = IDLE; err_d = 1'b1;
      end
      RD_PH: if (accept) begin
        state_d = RD_AL; wrt_d = 1'b1; cmd_d = 16'hAC00; ld_ph = 1'b1;
      end else if (expire) begin
        state_d = IDLE; err_d = 1'b1;
      end
      RD_AL: if (accept) begin
        state_d = RD_AH; wrt_d = 1'b1; cmd_d = 16'hAD00; ld_al = 1'b1;
      end else if (expire) begin
        state_d = IDLE; err_d = 1'b1;
      end
      // The last byte goes straight into AZ so vld and the new sample
      // appear together in the SAMPLE cycle.
      RD_AH: if (accept) begin
        state_d = SAMPLE; vld_d = 1'b1; ld_out = 1'b1;
      end else if (expire) begin
        state_d = IDLE; err_d = 1'b1;
      end
      SAMPLE:  state_d = IDLE;
      default: state_d = INIT_WAIT;
    endcase
  end

  // Stage p0: control state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT_WAIT;
      init_cnt <= '0;
      wrt      <= 1'b0;
      cmd      <= '0;
      vld      <= 1'b0;
      err      <= 1'b0;
      ptch_rt  <= '0;
      AZ       <= '0;
    end else begin
      state    <= state_d;
      init_cnt <= (state == INIT_WAIT) ? init_cnt + INIT_W'(1) : '0;
      wrt      <= wrt_d;
      cmd      <= cmd_d;
      vld      <= vld_d;
      err      <= err_d;
      if (ld_out) begin
        ptch_rt <= signed'({ptch_hi, ptch_lo});
        AZ      <= signed'({rd_data[7:0], az_lo});
      end
    end
  end

  // Byte holding registers; every read sequence rewrites all of them first.
  always_ff @(posedge clk) begin
    if (ld_pl) ptch_lo <= rd_data[7:0];
    if (ld_ph) ptch_hi <= rd_data[7:0];
    if (ld_al) az_lo   <= rd_data[7:0];
  end

endmodule

// File: tb/tb_inertial_interface.sv
module tb_inertial_interface;

  localparam int unsigned INIT_C = 64;
  localparam int unsigned TO_C   = 32;
  localparam time         T      = 10;

  logic clk = 1'b0, rst = 1'b1, INT = 1'b0, done = 1'b0;
  logic [15:0] rd_data = '0;
  logic wrt, vld, err;
  logic [15:0] cmd;
  logic signed [15:0] ptch_rt, AZ;

  inertial_interface #(.INIT_CYCLES(INIT_C), .TIMEOUT_CYCLES(TO_C)) dut (
    .clk(clk), .rst(rst), .INT(INT), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .vld(vld), .ptch_rt(ptch_rt), .AZ(AZ), .err(err)
  );

  always #(T/2) clk = ~clk;

  int tests = 0, fails = 0;
  logic [15:0] cmd_q[$];
  int vld_n = 0, err_n = 0, hold_viol = 0;
  logic [15:0] last_pr = '0, last_az = '0, prev_pr = '0, prev_az = '0;
  time vld_t = 0, err_t = 0, ac_wrt_t = 0, ah_done_t = 0;
  logic [7:0] resp_b[4];
  logic [15:0] hang_cmd = 16'h0000;
  bit spur_req = 1'b0;
  int dly_min = 1, dly_max = 4;

  localparam logic [15:0] CFG_CMDS[4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
  localparam logic [15:0] RD_CMDS[4]  = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};

  function automatic logic [7:0] byte_for(input logic [15:0] c);
    case (c)
      16'hA200: return resp_b[0];
      16'hA300: return resp_b[1];
      16'hAC00: return resp_b[2];
      16'hAD00: return resp_b[3];
      default:  return 8'($urandom);
    endcase
  endfunction

  // SPI master model: answers each wrt after a random delay, sometimes
  // raises a bogus done during the wrt cycle, never answers hang_cmd.
  initial begin : spi_model
    int cnt;
    logic [15:0] cur;
    cnt = 0;
    cur = '0;
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (spur_req) begin
        done = 1'b1; rd_data = 16'($urandom); spur_req = 1'b0;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          done = 1'b1;
          rd_data = {8'($urandom), byte_for(cur)};
          if (cur == 16'hAD00) ah_done_t = $time;
        end
      end
      if (wrt === 1'b1) begin
        cur = cmd;
        cnt = (cmd == hang_cmd) ? 0 : $urandom_range(dly_max, dly_min);
        if ($urandom_range(1, 0) == 1) begin
          done = 1'b1; rd_data = 16'($urandom);
        end
      end
    end
  end

  // Observer: logs commands, samples, errors and any output change without vld.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (wrt === 1'b1) begin
        cmd_q.push_back(cmd);
        if (cmd == 16'hAC00) ac_wrt_t = $time;
      end
      if (vld === 1'b1) begin
        vld_n++; last_pr = ptch_rt; last_az = AZ; vld_t = $time;
      end
      if (err === 1'b1) begin
        err_n++; err_t = $time;
      end
      if (vld !== 1'b1 && rst === 1'b0 && (ptch_rt !== prev_pr || AZ !== prev_az))
        hold_viol++;
      prev_pr = ptch_rt;
      prev_az = AZ;
    end
  end

  initial begin : watchdog
    #(400000 * T);
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_q(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && cmd_q.size() < n; i++) @(negedge clk);
    ok = (cmd_q.size() >= n);
  endtask

  task automatic wait_vld(input int n0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && vld_n <= n0; i++) @(negedge clk);
    ok = (vld_n > n0);
  endtask

  task automatic pulse_int();
    tick(1);
    INT = 1'b1;
    tick($urandom_range(5, 1));
    INT = 1'b0;
  endtask

  task automatic test_reset();
    int k;
    bit ok;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({wrt, vld, err} !== 3'b000) begin
      fails++; $display("FAIL reset_ctrl: wrt/vld/err=%b expected 000", {wrt, vld, err});
    end
    tests++;
    if (cmd !== 16'h0) begin fails++; $display("FAIL reset_cmd: got %h expected 0000", cmd); end
    tests++;
    if (ptch_rt !== 16'sh0 || AZ !== 16'sh0) begin
      fails++; $display("FAIL reset_data: ptch_rt=%h AZ=%h expected 0000/0000", ptch_rt, AZ);
    end
    @(posedge clk); #2;
    cmd_q.delete();
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < INIT_C + 8; i++) begin
      @(posedge clk); #1;
      k++;
      if (wrt === 1'b1) break;
    end
    tests++;
    if (k != INIT_C) begin fails++; $display("FAIL init_latency: got %0d cycles expected %0d", k, INIT_C); end
    wait_q(4, 200, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL cfg_timeout: got %0d cmds expected 4", cmd_q.size()); end
    tick(12);
    tests++;
    if (cmd_q.size() != 4) begin fails++; $display("FAIL cfg_count: got %0d expected 4", cmd_q.size()); end
    for (int i = 0; i < 4 && i < cmd_q.size(); i++) begin
      tests++;
      if (cmd_q[i] !== CFG_CMDS[i]) begin
        fails++; $display("FAIL cfg_cmd%0d: got %h expected %h", i, cmd_q[i], CFG_CMDS[i]);
      end
    end
    tests++;
    if (vld_n != 0) begin fails++; $display("FAIL cfg_no_vld: got %0d vld expected 0", vld_n); end
  endtask

  task automatic test_read(input logic [7:0] b0, b1, b2, b3, input string nm);
    int n0, hv0;
    bit ok;
    resp_b = '{b0, b1, b2, b3};
    cmd_q.delete();
    n0 = vld_n; hv0 = hold_viol;
    pulse_int();
    wait_vld(n0, 200, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL %s_vld_timeout: got %0d vld expected %0d", nm, vld_n, n0 + 1); end
    tick(10);
    tests++;
    if (cmd_q.size() != 4) begin fails++; $display("FAIL %s_cmd_count: got %0d expected 4", nm, cmd_q.size()); end
    for (int i = 0; i < 4 && i < cmd_q.size(); i++) begin
      tests++;
      if (cmd_q[i] !== RD_CMDS[i]) begin
        fails++; $display("FAIL %s_cmd%0d: got %h expected %h", nm, i, cmd_q[i], RD_CMDS[i]);
      end
    end
    tests++;
    if (vld_n != n0 + 1) begin fails++; $display("FAIL %s_vld_count: got %0d expected %0d", nm, vld_n - n0, 1); end
    tests++;
    if (last_pr !== {b1, b0}) begin fails++; $display("FAIL %s_ptch: got %h expected %h", nm, last_pr, {b1, b0}); end
    tests++;
    if (last_az !== {b3, b2}) begin fails++; $display("FAIL %s_az: got %h expected %h", nm, last_az, {b3, b2}); end
    tests++;
    if (vld_t - ah_done_t != T) begin
      fails++; $display("FAIL %s_latency: got %0t expected %0t", nm, vld_t - ah_done_t, T);
    end
    tests++;
    if (hold_viol != hv0 || ptch_rt !== {b1, b0} || AZ !== {b3, b2}) begin
      fails++; $display("FAIL %s_hold: changes %0d ptch_rt=%h AZ=%h expected 0 %h %h",
                        nm, hold_viol - hv0, ptch_rt, AZ, {b1, b0}, {b3, b2});
    end
  endtask

  task automatic test_stray_done();
    int n0;
    cmd_q.delete();
    n0 = vld_n;
    tick(1);
    spur_req = 1'b1;
    tick(10);
    tests++;
    if (cmd_q.size() != 0 || vld_n != n0) begin
      fails++; $display("FAIL stray_done: got %0d cmds %0d vld expected 0 0", cmd_q.size(), vld_n - n0);
    end
  endtask

  task automatic test_int_during_read();
    int n0;
    bit ok;
    resp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    cmd_q.delete();
    n0 = vld_n;
    dly_min = 8; dly_max = 10;
    pulse_int();
    wait_q(2, 100, ok);
    pulse_int();
    wait_vld(n0, 200, ok);
    tick(30);
    dly_min = 1; dly_max = 4;
    tests++;
    if (cmd_q.size() != 4) begin fails++; $display("FAIL int_in_read_cmds: got %0d expected 4", cmd_q.size()); end
    tests++;
    if (vld_n != n0 + 1) begin fails++; $display("FAIL int_in_read_vld: got %0d expected 1", vld_n - n0); end
    tests++;
    if (last_pr !== 16'h2211 || last_az !== 16'h4433) begin
      fails++; $display("FAIL int_in_read_data: got %h %h expected 2211 4433", last_pr, last_az);
    end
  endtask

  task automatic test_int_held();
    int n0;
    bit ok;
    resp_b = '{8'h5A, 8'hA5, 8'h01, 8'hFE};
    cmd_q.delete();
    n0 = vld_n;
    tick(1);
    INT = 1'b1;
    wait_vld(n0, 200, ok);
    tick(60);
    tests++;
    if (cmd_q.size() != 4 || vld_n != n0 + 1) begin
      fails++; $display("FAIL int_held: got %0d cmds %0d vld expected 4 1", cmd_q.size(), vld_n - n0);
    end
    INT = 1'b0;
    tick(5);
  endtask

  task automatic test_rst_mid();
    int n0;
    bit ok;
    resp_b = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    cmd_q.delete();
    n0 = vld_n;
    dly_min = 3; dly_max = 4;
    pulse_int();
    wait_q(3, 100, ok);
    tick(1);
    rst = 1'b1;
    tick(2);
    tests++;
    if (ptch_rt !== 16'sh0 || AZ !== 16'sh0 || wrt !== 1'b0 || vld !== 1'b0 || cmd !== 16'h0) begin
      fails++; $display("FAIL rst_mid_values: ptch_rt=%h AZ=%h wrt=%b vld=%b cmd=%h expected all 0",
                        ptch_rt, AZ, wrt, vld, cmd);
    end
    rst = 1'b0;
    dly_min = 1; dly_max = 4;
    wait_q(7, INIT_C + 200, ok);
    tick(20);
    tests++;
    if (cmd_q.size() != 7) begin fails++; $display("FAIL rst_mid_cmd_count: got %0d expected 7", cmd_q.size()); end
    for (int i = 0; i < 4 && i + 3 < cmd_q.size(); i++) begin
      tests++;
      if (cmd_q[i + 3] !== CFG_CMDS[i]) begin
        fails++; $display("FAIL rst_mid_cfg%0d: got %h expected %h", i, cmd_q[i + 3], CFG_CMDS[i]);
      end
    end
    tests++;
    if (vld_n != n0) begin fails++; $display("FAIL rst_mid_no_vld: got %0d expected 0", vld_n - n0); end
  endtask

`ifdef INERTIAL_TIMEOUT_EN
  task automatic test_timeout();
    int n0, e0;
    logic [15:0] pr, az;
    bit ok;
    pr = ptch_rt; az = AZ;
    resp_b = '{8'h99, 8'h88, 8'h77, 8'h66};
    n0 = vld_n; e0 = err_n;
    cmd_q.delete();
    hang_cmd = 16'hAC00;
    pulse_int();
    for (int i = 0; i < TO_C + 100 && err_n == e0; i++) @(negedge clk);
    tests++;
    if (err_n == e0) begin fails++; $display("FAIL timeout_err: got no err expected one pulse"); end
    tests++;
    if (err_t - ac_wrt_t != TO_C * T) begin
      fails++; $display("FAIL timeout_delay: got %0t expected %0t", err_t - ac_wrt_t, TO_C * T);
    end
    tick(10);
    hang_cmd = 16'h0000;
    tests++;
    if (err_n != e0 + 1 || vld_n != n0 || cmd_q.size() != 3) begin
      fails++; $display("FAIL timeout_abort: got err %0d vld %0d cmds %0d expected 1 0 3",
                        err_n - e0, vld_n - n0, cmd_q.size());
    end
    tests++;
    if (ptch_rt !== pr || AZ !== az) begin
      fails++; $display("FAIL timeout_hold: got %h %h expected %h %h", ptch_rt, AZ, pr, az);
    end
  endtask
`else
  task automatic test_no_err();
    tests++;
    if (err_n != 0) begin fails++; $display("FAIL err_tied: got %0d err pulses expected 0", err_n); end
  endtask
`endif

  initial begin
    test_reset();
    test_read(8'h34, 8'h12, 8'hCD, 8'hAB, "read1");
    test_read(8'hFF, 8'h7F, 8'h00, 8'h80, "read2");
    for (int i = 0; i < 4; i++)
      test_read(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), "rand");
    test_stray_done();
    test_int_during_read();
    test_read(8'h0F, 8'hF0, 8'h55, 8'hAA, "after_drop");
    test_int_held();
    test_rst_mid();
    test_read(8'h78, 8'h56, 8'h21, 8'h43, "after_rst");
`ifdef INERTIAL_TIMEOUT_EN
    test_timeout();
    test_read(8'hEF, 8'hBE, 8'hAD, 8'hDE, "after_timeout");
`else
    test_no_err();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
